// File: rtl/image_audio_merger.sv
// image_audio_merger
//
// Transmit-side payload assembler. Packs a pixel stream (tagged with a 24-bit
// frame address) and an optional buffered audio stream into fixed-format
// packets, emitted as a contiguous dibit stream to eth_packer.
//
// Packet layout (each byte sent LSB dibit first):
//   3 address bytes (MSB byte first), PIXELS_PER_PACKET pixel bytes,
//   then AUDIO_PER_PACKET audio bytes (audio build only).
//
// Build option:
//   IMAGE_AUDIO_MERGER_AUDIO_EN  defined   -> audio FIFO and AUDIO segment present
//                                undefined -> no FIFO, audio_ready tied low,
//                                             PIXEL segment goes straight to GAP
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   pixel_axiiv  in   pixel byte valid
//   pixel_axiid  in   pixel byte
//   pixel_addr   in   frame address, sampled on the first pixel of a packet
//   pixel_ready  out  pixel accepted this cycle
//   audio_axiiv  in   audio byte valid
//   audio_axiid  in   audio byte
//   audio_ready  out  audio FIFO not full
//   stall        in   eth_packer busy; only blocks packet start
//   axiov        out  dibit valid
//   axiod        out  dibit
//   underrun     out  pulse when a missing pixel byte is replaced by 0x00

module image_audio_merger #(
    parameter int PIXELS_PER_PACKET = 256,
    parameter int AUDIO_PER_PACKET  = 16,
    parameter int AUDIO_FIFO_DEPTH  = 64,
    parameter int GAP_CYCLES        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_axiiv,
    input  logic [7:0]  pixel_axiid,
    input  logic [23:0] pixel_addr,
    output logic        pixel_ready,
    input  logic        audio_axiiv,
    input  logic [7:0]  audio_axiid,
    output logic        audio_ready,
    input  logic        stall,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        underrun
);

    localparam int PW = $clog2(PIXELS_PER_PACKET + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS_PER_PACKET);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_PIXEL = 3'd2;
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
    localparam logic [2:0] S_AUDIO = 3'd3;
`endif
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    state;
    logic [1:0]    dib_idx;      // index of the dibit currently on axiod
    logic [1:0]    addr_idx;     // address byte currently being sent
    logic [15:0]   addr_lo;      // the two address bytes still to send
    logic [7:0]    pix_hold;     // first pixel, held while the header goes out
    logic [5:0]    tx_rest;      // remaining upper dibits of the byte in flight
    logic [PW-1:0] pix_cnt;
    logic [GW-1:0] gap_cnt;

    logic          last_dib;
    logic          pix_xfer;
    logic [7:0]    pix_byte;
    logic [7:0]    next_addr_byte;
    logic [1:0]    shift_dibit;

    assign last_dib = (dib_idx == 2'd3);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        pixel_ready = 1'b0;
        if (!rst) begin
            if (state == S_IDLE)
                pixel_ready = !stall;
            else if (state == S_PIXEL)
                pixel_ready = last_dib && (pix_cnt < PIX_LAST);
        end
    end

    assign pix_xfer = pixel_ready && pixel_axiiv;
    // A PIXEL-state ready slot with no valid pixel is filled with zero.
    assign underrun = pixel_ready && (state == S_PIXEL) && !pixel_axiiv;
    assign pix_byte = pixel_axiiv ? pixel_axiid : 8'h00;

    always_comb begin
        next_addr_byte = addr_lo[7:0];
        if (addr_idx == 2'd0)
            next_addr_byte = addr_lo[15:8];
    end

    always_comb begin
        shift_dibit = tx_rest[5:4];
        case (dib_idx)
            2'd0:    shift_dibit = tx_rest[1:0];
            2'd1:    shift_dibit = tx_rest[3:2];
            default: shift_dibit = tx_rest[5:4];
        endcase
    end

`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
    localparam int AW  = (AUDIO_FIFO_DEPTH > 1) ? $clog2(AUDIO_FIFO_DEPTH) : 1;
    localparam int AUW = $clog2(AUDIO_PER_PACKET + 1);
    localparam logic [AUW-1:0] AUD_LAST  = AUW'(AUDIO_PER_PACKET);
    localparam logic [AW:0]    FILL_FULL = (AW + 1)'(AUDIO_FIFO_DEPTH);

    logic [7:0]     fifo_mem [2**AW];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    fill;
    logic           fifo_empty;
    logic           fifo_full;
    logic           audio_wr;
    logic           audio_pop;
    logic [7:0]     audio_byte;
    logic [AUW-1:0] aud_cnt;

    // Extra pointer bit distinguishes full from empty; pointers wrap freely.
    assign fill       = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fill == FILL_FULL);
    assign audio_ready = !rst && !fifo_full;
    assign audio_wr    = audio_axiiv && audio_ready;

    // A byte is popped when the AUDIO segment begins and at each following
    // byte boundary inside it; an empty FIFO yields zero padding.
    assign audio_pop  = !fifo_empty &&
                        (((state == S_PIXEL) && last_dib && (pix_cnt == PIX_LAST)) ||
                         ((state == S_AUDIO) && last_dib && (aud_cnt < AUD_LAST)));
    assign audio_byte = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; emptiness is defined purely by the
    // pointers, so clearing them is enough and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (audio_wr)
            fifo_mem[wr_ptr[AW-1:0]] <= audio_axiid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (audio_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (audio_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
`else
    assign audio_ready = 1'b0;
    wire unused_audio = &{1'b0, audio_axiiv, audio_axiid};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dib_idx  <= 2'd0;
            addr_idx <= 2'd0;
            addr_lo  <= 16'h0000;
            pix_hold <= 8'h00;
            tx_rest  <= 6'h00;
            pix_cnt  <= '0;
            gap_cnt  <= '0;
            axiov    <= 1'b0;
            axiod    <= 2'b00;
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
            aud_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pix_xfer) begin
                        // First header dibit goes out on the very next cycle.
                        addr_lo  <= pixel_addr[15:0];
                        pix_hold <= pixel_axiid;
                        pix_cnt  <= PW'(1);
                        addr_idx <= 2'd0;
                        dib_idx  <= 2'd0;
                        axiov    <= 1'b1;
                        axiod    <= pixel_addr[17:16];
                        tx_rest  <= pixel_addr[23:18];
                        state    <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (!last_dib) begin
                        dib_idx <= dib_idx + 1'b1;
                        axiod   <= shift_dibit;
                    end else if (addr_idx != 2'd2) begin
                        addr_idx <= addr_idx + 1'b1;
                        dib_idx  <= 2'd0;
                        axiod    <= next_addr_byte[1:0];
                        tx_rest  <= next_addr_byte[7:2];
                    end else begin
                        dib_idx <= 2'd0;
                        axiod   <= pix_hold[1:0];
                        tx_rest <= pix_hold[7:2];
                        state   <= S_PIXEL;
                    end
                end

                S_PIXEL: begin
                    if (!last_dib) begin
                        dib_idx <= dib_idx + 1'b1;
                        axiod   <= shift_dibit;
                    end else if (pix_cnt < PIX_LAST) begin
                        // pixel_ready is high here: take the byte or pad it.
                        pix_cnt <= pix_cnt + 1'b1;
                        dib_idx <= 2'd0;
                        axiod   <= pix_byte[1:0];
                        tx_rest <= pix_byte[7:2];
                    end else begin
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
                        aud_cnt <= AUW'(1);
                        dib_idx <= 2'd0;
                        axiod   <= audio_byte[1:0];
                        tx_rest <= audio_byte[7:2];
                        state   <= S_AUDIO;
`else
                        axiov   <= 1'b0;
                        axiod   <= 2'b00;
                        gap_cnt <= '0;
                        state   <= S_GAP;
`endif
                    end
                end

`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
                S_AUDIO: begin
                    if (!last_dib) begin
                        dib_idx <= dib_idx + 1'b1;
                        axiod   <= shift_dibit;
                    end else if (aud_cnt < AUD_LAST) begin
                        aud_cnt <= aud_cnt + 1'b1;
                        dib_idx <= 2'd0;
                        axiod   <= audio_byte[1:0];
                        tx_rest <= audio_byte[7:2];
                    end else begin
                        axiov   <= 1'b0;
                        axiod   <= 2'b00;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
`endif

                S_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_audio_merger.sv
module tb_image_audio_merger;

    localparam int P     = 4;
    localparam int A     = 2;
    localparam int G     = 2;
    localparam int DEPTH = 64;
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
    localparam int PKT_DIBITS = 12 + 4 * P + 4 * A;
`else
    localparam int PKT_DIBITS = 12 + 4 * P;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_axiiv;
    logic [7:0]  pixel_axiid;
    logic [23:0] pixel_addr;
    logic        pixel_ready;
    logic        audio_axiiv;
    logic [7:0]  audio_axiid;
    logic        audio_ready;
    logic        stall;
    logic        axiov;
    logic [1:0]  axiod;
    logic        underrun;

    always #5 clk = ~clk;

    image_audio_merger #(
        .PIXELS_PER_PACKET (P),
        .AUDIO_PER_PACKET  (A),
        .AUDIO_FIFO_DEPTH  (DEPTH),
        .GAP_CYCLES        (G)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_axiiv (pixel_axiiv),
        .pixel_axiid (pixel_axiid),
        .pixel_addr  (pixel_addr),
        .pixel_ready (pixel_ready),
        .audio_axiiv (audio_axiiv),
        .audio_axiid (audio_axiid),
        .audio_ready (audio_ready),
        .stall       (stall),
        .axiov       (axiov),
        .axiod       (axiod),
        .underrun    (underrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pix_q [P];
    logic [7:0] aud_q [A];
    logic [1:0] got_q [$];
    logic [1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++)
            exp_q.push_back(b[2*k +: 2]);
    endtask

    task automatic push_audio(input logic [7:0] b);
        @(negedge clk);
        audio_axiiv = 1'b1;
        audio_axiid = b;
        #1;
        check("aud_push_ready", {31'd0, audio_ready}, 32'd1);
        @(negedge clk);
        audio_axiiv = 1'b0;
    endtask

    // Drives one packet's pixels, captures the dibit stream and checks it
    // against the byte sequence expected for addr / pix_q / aud_q.
    // drop_at: pixel index withheld (-1 for none); abort_after: stop after
    // that many dibits (0 for a full packet).
    task automatic run_packet(input string name, input logic [23:0] addr,
                              input int drop_at, input int stall_cycles,
                              input int abort_after);
        int idx = 0;
        int cyc = 0;
        int first_v = -1;
        int n_under = 0;
        int n_rdy = 0;
        int n_cmp;
        bit started = 1'b0;
        bit done = 1'b0;
        bit stall_ok = 1'b1;
        bit aready_ok = 1'b1;

        got_q.delete();
        exp_q.delete();
        push_byte(addr[23:16]);
        push_byte(addr[15:8]);
        push_byte(addr[7:0]);
        for (int i = 0; i < P; i++)
            push_byte((i == drop_at) ? 8'h00 : pix_q[i]);
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
        for (int i = 0; i < A; i++)
            push_byte(aud_q[i]);
`endif

        while (!done && cyc < 300) begin
            @(negedge clk);
            stall       = (cyc < stall_cycles);
            pixel_addr  = addr;
            pixel_axiiv = (idx < P) && (idx != drop_at);
            pixel_axiid = (idx < P) ? pix_q[idx] : 8'h00;
`ifndef IMAGE_AUDIO_MERGER_AUDIO_EN
            audio_axiiv = 1'b1;
            audio_axiid = 8'(cyc * 37 + 5);
`endif
            #1;
            if (cyc < stall_cycles && (pixel_ready || axiov))
                stall_ok = 1'b0;
            if (audio_ready)
                aready_ok = 1'b0;
            if (axiov) begin
                if (!started)
                    first_v = cyc;
                started = 1'b1;
                got_q.push_back(axiod);
                if (pixel_ready)
                    n_rdy++;
            end else if (started) begin
                done = 1'b1;
            end
            if (underrun)
                n_under++;
            if ((pixel_ready && pixel_axiiv) || underrun)
                idx++;
            cyc++;
            if (abort_after > 0 && got_q.size() == abort_after)
                break;
        end
        pixel_axiiv = 1'b0;
        audio_axiiv = 1'b0;
        stall       = 1'b0;

        check({name, "_start"}, first_v, stall_cycles + 1);
        if (abort_after > 0) begin
            check({name, "_abort_len"}, got_q.size(), abort_after);
            return;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        if (stall_cycles > 0)
            check({name, "_stall_quiet"}, {31'd0, stall_ok}, 32'd1);
`ifndef IMAGE_AUDIO_MERGER_AUDIO_EN
        check({name, "_audio_ready_low"}, {31'd0, aready_ok}, 32'd1);
`endif
        check({name, "_len"}, got_q.size(), PKT_DIBITS);
        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++)
            check($sformatf("%s_dibit%0d", name, i), {30'd0, got_q[i]}, {30'd0, exp_q[i]});
        check({name, "_underruns"}, n_under, (drop_at >= 0) ? 1 : 0);
        check({name, "_ready_pulses"}, n_rdy, P - 1);

        // done was seen on the first gap cycle; the second must be quiet too
        @(negedge clk);
        #1;
        check({name, "_gap2"}, {31'd0, axiov}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        pixel_axiiv = 1'b0;
        pixel_axiid = 8'h00;
        pixel_addr  = 24'h0;
        audio_axiiv = 1'b0;
        audio_axiid = 8'h00;

        // ---- reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_axiov",       {31'd0, axiov},       32'd0);
        check("rst_axiod",       {30'd0, axiod},       32'd0);
        check("rst_pixel_ready", {31'd0, pixel_ready}, 32'd0);
        check("rst_audio_ready", {31'd0, audio_ready}, 32'd0);
        check("rst_underrun",    {31'd0, underrun},    32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_pixel_ready", {31'd0, pixel_ready}, 32'd1);
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
        check("post_rst_audio_ready", {31'd0, audio_ready}, 32'd1);
`else
        check("post_rst_audio_ready", {31'd0, audio_ready}, 32'd0);
`endif

        // ---- basic packet
        pix_q = '{8'h1B, 8'h2C, 8'h3D, 8'h4E};
        aud_q = '{8'hA5, 8'h5A};
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
        push_audio(8'hA5);
        push_audio(8'h5A);
`endif
        run_packet("basic", 24'h012345, -1, 0, 0);
        if (got_q.size() >= 16) begin
            // 0x01 -> 1,0,0,0 ; 0x1B -> 3,2,1,0
            check("basic_hdr0", {30'd0, got_q[0]},  32'd1);
            check("basic_hdr1", {30'd0, got_q[1]},  32'd0);
            check("basic_hdr2", {30'd0, got_q[2]},  32'd0);
            check("basic_hdr3", {30'd0, got_q[3]},  32'd0);
            check("basic_px0",  {30'd0, got_q[12]}, 32'd3);
            check("basic_px1",  {30'd0, got_q[13]}, 32'd2);
            check("basic_px2",  {30'd0, got_q[14]}, 32'd1);
            check("basic_px3",  {30'd0, got_q[15]}, 32'd0);
        end
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
        if (got_q.size() >= 36) begin
            // 0xA5 -> 1,1,2,2 ; 0x5A -> 2,2,1,1
            check("basic_aud0", {30'd0, got_q[28]}, 32'd1);
            check("basic_aud1", {30'd0, got_q[29]}, 32'd1);
            check("basic_aud2", {30'd0, got_q[30]}, 32'd2);
            check("basic_aud3", {30'd0, got_q[31]}, 32'd2);
            check("basic_aud4", {30'd0, got_q[32]}, 32'd2);
            check("basic_aud7", {30'd0, got_q[35]}, 32'd1);
        end
`endif

        // ---- pixel starvation before pixel 3, empty audio FIFO
        aud_q = '{8'h00, 8'h00};
        run_packet("starve", 24'h012345, 2, 0, 0);
        if (got_q.size() >= 24) begin
            check("starve_px3_d0", {30'd0, got_q[20]}, 32'd0);
            check("starve_px3_d3", {30'd0, got_q[23]}, 32'd0);
            // pixel 4 (0x4E -> 2,3,0,1) still follows
            check("starve_px4_d0", {30'd0, got_q[24]}, 32'd2);
        end

        // ---- stall held for 10 cycles with a pixel pending
        pix_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_packet("stall", 24'hABCDEF, -1, 10, 0);
`ifdef IMAGE_AUDIO_MERGER_AUDIO_EN
        if (got_q.size() >= 36) begin
            for (int i = 28; i < 36; i++)
                check($sformatf("stall_aud_zero%0d", i), {30'd0, got_q[i]}, 32'd0);
        end

        // ---- FIFO full: 70 back-to-back writes, only 64 stored
        begin
            int accepted = 0;
            for (int i = 0; i < 70; i++) begin
                @(negedge clk);
                audio_axiiv = 1'b1;
                audio_axiid = 8'(i + 1);
                #1;
                if (i == 63)
                    check("fifo_ready_at_64", {31'd0, audio_ready}, 32'd1);
                if (i == 64)
                    check("fifo_ready_after_64", {31'd0, audio_ready}, 32'd0);
                if (audio_ready)
                    accepted++;
            end
            @(negedge clk);
            audio_axiiv = 1'b0;
            check("fifo_accepted", accepted, 64);
        end
        for (int k = 0; k < 32; k++) begin
            aud_q = '{8'(2 * k + 1), 8'(2 * k + 2)};
            run_packet($sformatf("drain%0d", k), 24'h102030, -1, 0, 0);
            if (k == 0) begin
                #1;
                check("fifo_ready_after_pop", {31'd0, audio_ready}, 32'd1);
            end
        end
        push_audio(8'hA5);
        push_audio(8'h5A);
`endif

        // ---- reset during the PIXEL segment
        pix_q = '{8'h1B, 8'h2C, 8'h3D, 8'h4E};
        run_packet("abort", 24'h012345, -1, 0, 16);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_axiov",       {31'd0, axiov},       32'd0);
        check("mid_rst_pixel_ready", {31'd0, pixel_ready}, 32'd0);
        check("mid_rst_underrun",    {31'd0, underrun},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_release_ready", {31'd0, pixel_ready}, 32'd1);
        pix_q = '{8'h5A, 8'hA5, 8'h0F, 8'hF0};
        aud_q = '{8'h00, 8'h00};
        run_packet("after_rst", 24'hC3F00D, -1, 0, 0);
        if (got_q.size() >= 4) begin
            // 0xC3 -> 3,0,0,3
            check("after_rst_hdr0", {30'd0, got_q[0]}, 32'd3);
            check("after_rst_hdr1", {30'd0, got_q[1]}, 32'd0);
            check("after_rst_hdr3", {30'd0, got_q[3]}, 32'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/image_audio_merger.md
# image_audio_merger

Transmit-side payload assembler, the counterpart of `image_audio_splitter`. It takes a pixel stream tagged with 24-bit frame addresses, plus a byte-wide audio stream, and packs them into fixed-format packets. Each packet is emitted as a 2-bit dibit stream into `eth_packer`, which adds the Ethernet framing. A buffered audio FIFO and a header/pixel/audio sequencer make sure the far-end splitter sees exactly the field order it decodes.

## Interface
Parameters:
- `PIXELS_PER_PACKET`, 256: pixel bytes per packet, ≥1.
- `AUDIO_PER_PACKET`, 16: audio bytes per packet, ≥1.
- `AUDIO_FIFO_DEPTH`, 64: audio FIFO entries, power of two, ≥ `AUDIO_PER_PACKET`.
- `GAP_CYCLES`, 2: minimum `axiov`-low cycles between packets, ≥1.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pixel_axiiv` in 1: pixel byte valid.
- `pixel_axiid` in 8: pixel byte.
- `pixel_addr` in 24: frame address of the presented pixel. It is sampled only on the first pixel of each packet.
- `pixel_ready` out 1: the merger accepts the pixel this cycle.
- `audio_axiiv` in 1: audio byte valid.
- `audio_axiid` in 8: audio byte.
- `audio_ready` out 1: the FIFO is not full.
- `stall` in 1: `eth_packer` busy (preamble, CRC, IFG).
- `axiov` out 1: dibit valid to `eth_packer`.
- `axiod` out 2: dibit.
- `underrun` out 1: one-cycle pulse when a pixel byte is zero-padded.

## Operation
- **Packet format:**
  - 3 address bytes, MSB byte first.
  - Then `PIXELS_PER_PACKET` pixel bytes.
  - Then `AUDIO_PER_PACKET` audio bytes.
  - Each byte is sent as 4 dibits, LSB dibit first (wire order, bits [1:0],[3:2],[5:4],[7:6]).
  - Packet length is 12 + 4·P + 4·A dibits, transmitted contiguously.
- **Pixel transfer:** a transfer occurs when `pixel_axiiv && pixel_ready`. Audio enters the FIFO when `audio_axiiv && audio_ready`. Simultaneous FIFO write and read are both honored.
- **FSM states:** IDLE, ADDR, PIXEL, AUDIO, GAP.
  - **IDLE:** `pixel_ready = !stall`. On a transfer, latch `pixel_addr` into the address register and the pixel byte into the pixel holding register, set `pix_cnt = 1`, and go to ADDR.
  - **ADDR:** emit 12 dibits from the latched address, then go to PIXEL.
  - **PIXEL:** shift out the held byte.
    - On its 4th dibit: if `pix_cnt < P`, assert `pixel_ready`. On a transfer, load the byte and increment `pix_cnt`.
    - If no pixel is valid, load 0x00, increment `pix_cnt`, and pulse `underrun`.
    - After the 4th dibit of pixel P, go to AUDIO.
  - **AUDIO:** pop one FIFO byte per 4 dibits. If the FIFO is empty, send 0x00. No underrun pulse is raised for audio. After A bytes, go to GAP.
  - **GAP:** `axiov = 0` for `GAP_CYCLES` cycles, then go to IDLE.
- **Stall handling:**
  - `stall` is honored only in IDLE: no packet starts while it is high.
  - `stall` rising mid-packet is ignored, because `eth_packer` never stalls mid-payload.
- **Audio FIFO:**
  - When the FIFO is full, `audio_ready = 0` and incoming bytes are not accepted.
  - Pointers are `$clog2(DEPTH)+1` bits wide and wrap naturally.
- **Reset:** a mid-packet reset aborts the packet immediately. `axiov` drops the same edge, and the FIFO empties.

## Timing
- **Reset values:** `axiov = 0`, `axiod = 0`, `pixel_ready = 0`, `audio_ready = 0`, `underrun = 0`. State is IDLE, all counters are 0, and the FIFO is empty.
- **Post-reset ready:** `pixel_ready` and `audio_ready` rise on the cycle after `rst` deasserts, with `pixel_ready` gated by `stall`.
- **Outputs are registered.** The first address dibit is valid the cycle after the IDLE transfer, giving a latency of 1 cycle.
- **Pixel handshake:** `pixel_ready` in PIXEL is high for exactly 1 cycle per byte, coincident with the last dibit of the previous byte. Output is therefore gapless.
- **`underrun`** is asserted in the same cycle the missing pixel would have transferred.
- **FIFO full:** `audio_ready` falls in the cycle after the write that fills the FIFO. It rises in the cycle after a pop from full.
- **Inter-packet spacing:** the minimum start-to-start spacing is 12 + 4P + 4A + GAP_CYCLES + 1 cycles.

## Configuration
- **`IMAGE_AUDIO_MERGER_AUDIO_EN` defined:** behaviour is as described above.
- **`IMAGE_AUDIO_MERGER_AUDIO_EN` undefined:**
  - The FIFO and the AUDIO state are not compiled.
  - `audio_ready` is tied to 0 and audio inputs are ignored.
  - PIXEL goes directly to GAP.
  - Packet length is 12 + 4·P dibits.

## Test plan
All scenarios use P=4, A=2, GAP_CYCLES=2 unless stated otherwise.
- **Basic packet (audio enabled):**
  - Stimulus: pixels 0x1B,0x2C,0x3D,0x4E with addr 0x012345 held valid continuously; audio 0xA5,0x5A preloaded.
  - Response: exactly 36 consecutive `axiov` dibits. The first 4 are 1,0,0,0 (byte 0x01). The pixel 0x1B dibits are 3,2,1,0. The last 8 dibits encode 0xA5,0x5A. `axiov` is then low for 2 cycles.
- **Pixel starvation:**
  - Stimulus: `pixel_axiiv` dropped before pixel 3.
  - Response: one `underrun` pulse, pixel 3 sent as four 0 dibits, packet still 36 dibits.
- **Stall and empty FIFO:**
  - Stimulus: `stall` held high for 10 cycles with a pixel valid in IDLE, and an empty audio FIFO.
  - Response: `pixel_ready` and `axiov` stay low for 10 cycles, and the packet starts the cycle after `stall` falls. The audio segment is 8 zero dibits.
- **FIFO full:**
  - Stimulus: 70 back-to-back audio writes with DEPTH=64.
  - Response: `audio_ready` falls after write 64, only the first 64 bytes are stored, and those bytes emerge in order across packets.
- **Reset mid-packet:**
  - Stimulus: `rst` asserted during the PIXEL state.
  - Response: `axiov` is 0 the next edge. The next packet starts with fresh header dibits for the new addr, and no stale audio is sent.
- **Audio disabled:**
  - Stimulus: macro undefined, basic packet stimulus.
  - Response: 28 dibits per packet and `audio_ready` constantly 0.
